// File: rtl/midi_msg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : midi_msg_decoder
// Brief    : Byte-level MIDI parser with running status, SysEx skip and
//            real-time passthrough. Optional macro: MIDI_VEL0_NOTE_OFF_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE         4
`define MIDI_CMD_NONE         4'd0
`define MIDI_CMD_NOTE_OFF     4'd1
`define MIDI_CMD_NOTE_ON      4'd2
`define MIDI_CMD_AFTERTOUCH   4'd3
`define MIDI_CMD_CC           4'd4
`define MIDI_CMD_PATCH_CHANGE 4'd5
`define MIDI_CMD_CH_PRESSURE  4'd6
`define MIDI_CMD_PITCH_BEND   4'd7
`define MIDI_CMD_SYS          4'd8
`endif

module midi_msg_decoder #(
    parameter bit REALTIME_OUT = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_rdy,
    input  logic [7:0]                rx_byte,
    output logic                      midi_rdy,
    output logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
    output logic [3:0]                midi_ch_sysn,
    output logic [6:0]                midi_data0,
    output logic [6:0]                midi_data1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA0 = 2'd1,
        ST_DATA1 = 2'd2,
        ST_SYSEX = 2'd3
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [3:0]                r_rs_hi, w_rs_hi_nxt;
    logic [3:0]                r_rs_ch, w_rs_ch_nxt;
    logic [6:0]                r_data0, w_data0_nxt;

    logic                      w_emit;
    logic [`MIDI_CMD_SIZE-1:0] w_cmd;
    logic [3:0]                w_ch;
    logic [6:0]                w_d0;
    logic [6:0]                w_d1;
    logic                      w_one_byte;

    logic                      r_midi_rdy;
    logic [`MIDI_CMD_SIZE-1:0] r_midi_cmd;
    logic [3:0]                r_midi_ch_sysn;
    logic [6:0]                r_midi_data0;
    logic [6:0]                r_midi_data1;

    function automatic logic [`MIDI_CMD_SIZE-1:0] f_map_cmd(input logic [3:0] hi);
        case (hi)
            4'h8:    f_map_cmd = `MIDI_CMD_NOTE_OFF;
            4'h9:    f_map_cmd = `MIDI_CMD_NOTE_ON;
            4'hA:    f_map_cmd = `MIDI_CMD_AFTERTOUCH;
            4'hB:    f_map_cmd = `MIDI_CMD_CC;
            4'hC:    f_map_cmd = `MIDI_CMD_PATCH_CHANGE;
            4'hD:    f_map_cmd = `MIDI_CMD_CH_PRESSURE;
            4'hE:    f_map_cmd = `MIDI_CMD_PITCH_BEND;
            default: f_map_cmd = `MIDI_CMD_NONE;
        endcase
    endfunction

    assign w_one_byte = (r_rs_hi == 4'hC) || (r_rs_hi == 4'hD);

    always_comb begin
        w_state_nxt = r_state;
        w_rs_hi_nxt = r_rs_hi;
        w_rs_ch_nxt = r_rs_ch;
        w_data0_nxt = r_data0;
        w_emit      = 1'b0;
        w_cmd       = `MIDI_CMD_NONE;
        w_ch        = 4'd0;
        w_d0        = 7'd0;
        w_d1        = 7'd0;
        if (rx_rdy) begin
            if (rx_byte[7]) begin
                if (rx_byte[7:4] != 4'hF) begin
                    w_state_nxt = ST_DATA0;
                    w_rs_hi_nxt = rx_byte[7:4];
                    w_rs_ch_nxt = rx_byte[3:0];
                end else if (rx_byte[3]) begin
                    // Real-time bytes are transparent to the parser state
                    if (REALTIME_OUT) begin
                        w_emit = 1'b1;
                        w_cmd  = `MIDI_CMD_SYS;
                        w_ch   = rx_byte[3:0];
                    end
                end else begin
                    w_state_nxt = (rx_byte == 8'hF0) ? ST_SYSEX : ST_IDLE;
                    w_rs_hi_nxt = 4'd0;
                    w_rs_ch_nxt = 4'd0;
                end
            end else begin
                case (r_state)
                    ST_DATA0: begin
                        if (w_one_byte) begin
                            w_emit = 1'b1;
                            w_cmd  = f_map_cmd(r_rs_hi);
                            w_ch   = r_rs_ch;
                            w_d0   = rx_byte[6:0];
                        end else begin
                            w_data0_nxt = rx_byte[6:0];
                            w_state_nxt = ST_DATA1;
                        end
                    end
                    ST_DATA1: begin
                        w_emit      = 1'b1;
                        w_cmd       = f_map_cmd(r_rs_hi);
                        w_ch        = r_rs_ch;
                        w_d0        = r_data0;
                        w_d1        = rx_byte[6:0];
                        w_state_nxt = ST_DATA0;
`ifdef MIDI_VEL0_NOTE_OFF_EN
                        if ((w_cmd == `MIDI_CMD_NOTE_ON) && (w_d1 == 7'd0)) begin
                            w_cmd = `MIDI_CMD_NOTE_OFF;
                        end
`else
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_rs_hi <= 4'd0;
            r_rs_ch <= 4'd0;
            r_data0 <= 7'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rs_hi <= w_rs_hi_nxt;
            r_rs_ch <= w_rs_ch_nxt;
            r_data0 <= w_data0_nxt;
        end
    end

    // Event fields only move together with the strobe and hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_midi_rdy     <= 1'b0;
            r_midi_cmd     <= `MIDI_CMD_NONE;
            r_midi_ch_sysn <= 4'd0;
            r_midi_data0   <= 7'd0;
            r_midi_data1   <= 7'd0;
        end else begin
            r_midi_rdy <= w_emit;
            if (w_emit) begin
                r_midi_cmd     <= w_cmd;
                r_midi_ch_sysn <= w_ch;
                r_midi_data0   <= w_d0;
                r_midi_data1   <= w_d1;
            end
        end
    end

    assign midi_rdy     = r_midi_rdy;
    assign midi_cmd     = r_midi_cmd;
    assign midi_ch_sysn = r_midi_ch_sysn;
    assign midi_data0   = r_midi_data0;
    assign midi_data1   = r_midi_data1;

endmodule

`default_nettype wire

// File: tb/tb_midi_msg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_msg_decoder
// Brief    : Directed table plus randomized stream against a message-level
//            reference model, for REALTIME_OUT=1 and REALTIME_OUT=0 instances.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE         4
`define MIDI_CMD_NONE         4'd0
`define MIDI_CMD_NOTE_OFF     4'd1
`define MIDI_CMD_NOTE_ON      4'd2
`define MIDI_CMD_AFTERTOUCH   4'd3
`define MIDI_CMD_CC           4'd4
`define MIDI_CMD_PATCH_CHANGE 4'd5
`define MIDI_CMD_CH_PRESSURE  4'd6
`define MIDI_CMD_PITCH_BEND   4'd7
`define MIDI_CMD_SYS          4'd8
`endif

module tb_midi_msg_decoder;

`ifdef MIDI_VEL0_NOTE_OFF_EN
    localparam logic [3:0] C_VEL0_CMD = `MIDI_CMD_NOTE_OFF;
`else
    localparam logic [3:0] C_VEL0_CMD = `MIDI_CMD_NOTE_ON;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       rx_rdy  = 1'b0;
    logic [7:0] rx_byte = 8'd0;

    logic       m1_rdy, m0_rdy;
    logic [3:0] m1_cmd, m0_cmd, m1_ch, m0_ch;
    logic [6:0] m1_d0, m0_d0, m1_d1, m0_d1;

    midi_msg_decoder #(.REALTIME_OUT(1'b1)) u_dut_rt1 (
        .clk(clk), .reset(reset), .rx_rdy(rx_rdy), .rx_byte(rx_byte),
        .midi_rdy(m1_rdy), .midi_cmd(m1_cmd), .midi_ch_sysn(m1_ch),
        .midi_data0(m1_d0), .midi_data1(m1_d1)
    );

    midi_msg_decoder #(.REALTIME_OUT(1'b0)) u_dut_rt0 (
        .clk(clk), .reset(reset), .rx_rdy(rx_rdy), .rx_byte(rx_byte),
        .midi_rdy(m0_rdy), .midi_cmd(m0_cmd), .midi_ch_sysn(m0_ch),
        .midi_data0(m0_d0), .midi_data1(m0_d1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: running status byte (-1 = none) plus pending data bytes
    int          rs = -1;
    int          q[$];
    logic [22:0] exp_out [2];

    function automatic logic [3:0] cmd_of(input int hi);
        case (hi)
            8:       return `MIDI_CMD_NOTE_OFF;
            9:       return `MIDI_CMD_NOTE_ON;
            10:      return `MIDI_CMD_AFTERTOUCH;
            11:      return `MIDI_CMD_CC;
            12:      return `MIDI_CMD_PATCH_CHANGE;
            13:      return `MIDI_CMD_CH_PRESSURE;
            14:      return `MIDI_CMD_PITCH_BEND;
            default: return `MIDI_CMD_NONE;
        endcase
    endfunction

    function automatic void model_reset();
        rs = -1;
        q.delete();
        exp_out[0] = 23'd0;
        exp_out[1] = 23'd0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] b);
        int          need;
        logic [3:0]  c;
        logic [6:0]  d0, d1;
        exp_out[0][22] = 1'b0;
        exp_out[1][22] = 1'b0;
        if (!v) return;
        if (b >= 8'hF8) begin
            exp_out[1] = {1'b1, `MIDI_CMD_SYS, b[3:0], 7'd0, 7'd0};
            return;
        end
        if (b[7]) begin
            q.delete();
            rs = (b < 8'hF0) ? int'(b) : -1;
            return;
        end
        if (rs < 0) return;
        q.push_back(int'(b));
        need = ((rs / 16) == 12 || (rs / 16) == 13) ? 1 : 2;
        if (q.size() == need) begin
            c  = cmd_of(rs / 16);
            d0 = 7'(q[0]);
            d1 = (need == 2) ? 7'(q[1]) : 7'd0;
            if (c == `MIDI_CMD_NOTE_ON && d1 == 7'd0) c = C_VEL0_CMD;
            exp_out[0] = {1'b1, c, 4'(rs % 16), d0, d1};
            exp_out[1] = exp_out[0];
            q.delete();
        end
    endfunction

    function automatic void check(input string name, input logic [22:0] got,
                                  input logic [22:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endfunction

    function automatic void check_both();
        check("rt1_vs_model", {m1_rdy, m1_cmd, m1_ch, m1_d0, m1_d1}, exp_out[1]);
        check("rt0_vs_model", {m0_rdy, m0_cmd, m0_ch, m0_d0, m0_d1}, exp_out[0]);
    endfunction

    task automatic cycle(input logic v, input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = v;
        rx_byte = b;
        model_step(v, b);
        @(posedge clk);
        #1;
        check_both();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rx_rdy = 1'b0;
        reset  = 1'b0;
        model_reset();
        #1;
        check_both();
        check("reset_outputs_zero", {m1_rdy, m1_cmd, m1_ch, m1_d0, m1_d1}, 23'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] b;
        logic       rdy;
        logic [3:0] cmd;
        logic [3:0] ch;
        logic [6:0] d0;
        logic [6:0] d1;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] b, input logic r,
                                input logic [3:0] c, input logic [3:0] ch,
                                input logic [6:0] d0, input logic [6:0] d1);
        vec_t e;
        e.v = v; e.b = b; e.rdy = r; e.cmd = c; e.ch = ch; e.d0 = d0; e.d1 = d1;
        tbl.push_back(e);
    endfunction

    function automatic void nb(input logic [7:0] b);
        add(1'b1, b, 1'b0, 4'd0, 4'd0, 7'd0, 7'd0);
    endfunction

    initial begin
        logic [7:0] b;
        logic       v;
        int         r;

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_both();
        check("reset_state", {m1_rdy, m1_cmd, m1_ch, m1_d0, m1_d1}, 23'd0);
        @(negedge clk);
        reset = 1'b1;

        nb(8'h92); nb(8'h3C);
        add(1, 8'h64, 1, `MIDI_CMD_NOTE_ON, 4'd2, 7'h3C, 7'h64);
        add(0, 8'h00, 0, 4'd0, 4'd0, 7'd0, 7'd0);
        nb(8'hB0); nb(8'h07);
        add(1, 8'h40, 1, `MIDI_CMD_CC, 4'd0, 7'h07, 7'h40);
        nb(8'h07);
        add(1, 8'h7F, 1, `MIDI_CMD_CC, 4'd0, 7'h07, 7'h7F);
        nb(8'h90); nb(8'h3C);
        add(1, 8'hF8, 1, `MIDI_CMD_SYS, 4'd8, 7'd0, 7'd0);
        add(1, 8'h40, 1, `MIDI_CMD_NOTE_ON, 4'd0, 7'h3C, 7'h40);
        nb(8'hF0); nb(8'h43); nb(8'h10); nb(8'hF7); nb(8'h10); nb(8'h20);
        nb(8'hC5);
        add(1, 8'h0A, 1, `MIDI_CMD_PATCH_CHANGE, 4'd5, 7'h0A, 7'd0);
        add(1, 8'h0B, 1, `MIDI_CMD_PATCH_CHANGE, 4'd5, 7'h0B, 7'd0);
        nb(8'h90); nb(8'h40);
        add(1, 8'h00, 1, C_VEL0_CMD, 4'd0, 7'h40, 7'd0);
        nb(8'h93); nb(8'h3C); nb(8'h8F); nb(8'h11);
        add(1, 8'h22, 1, `MIDI_CMD_NOTE_OFF, 4'hF, 7'h11, 7'h22);
        nb(8'hE1); nb(8'h00);
        add(1, 8'h40, 1, `MIDI_CMD_PITCH_BEND, 4'd1, 7'h00, 7'h40);
        nb(8'hF3); nb(8'h01);
        add(1, 8'hFE, 1, `MIDI_CMD_SYS, 4'hE, 7'd0, 7'd0);
        nb(8'h02);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].b);
            n_checks++;
            if (tbl[i].rdy ? ({m1_rdy, m1_cmd, m1_ch, m1_d0, m1_d1} ===
                              {1'b1, tbl[i].cmd, tbl[i].ch, tbl[i].d0, tbl[i].d1})
                           : (m1_rdy === 1'b0))
                n_pass++;
            else
                $display("FAIL table[%0d] byte=%h got=%b/%h/%h/%h/%h expected=%b/%h/%h/%h/%h",
                         i, tbl[i].b, m1_rdy, m1_cmd, m1_ch, m1_d0, m1_d1,
                         tbl[i].rdy, tbl[i].cmd, tbl[i].ch, tbl[i].d0, tbl[i].d1);
        end

        // Partial pitch bend discarded by reset; the lone data byte afterwards is dropped
        cycle(1'b1, 8'hE1);
        cycle(1'b1, 8'h00);
        pulse_reset();
        cycle(1'b1, 8'h40);
        check("post_reset_no_event", {31'd0, m1_rdy}, 32'd0);
        cycle(1'b0, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) pulse_reset();
            r = int'($urandom_range(0, 99));
            v = 1'b1;
            if (r < 40)      b = 8'($urandom_range(0, 127));
            else if (r < 65) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 80) b = 8'(8'hF8 + $urandom_range(0, 7));
            else if (r < 90) b = 8'(8'hF0 + $urandom_range(0, 7));
            else begin
                v = 1'b0;
                b = 8'($urandom_range(0, 255));
            end
            cycle(v, b);
        end
        cycle(1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
